// File: rtl/spin_step_pkg.sv
// spin_step_pkg: shared types and default constants for the segment-spinner
// step controller (spin_step_ctrl and its btn_debounce helper).
//
// Contents:
//   spin_state_t        run/pause/single-step state encoding
//   DEF_DIV_SHIFT_MIN   default log2 of the prescaler period at speed=0
//   DEF_DIV_WIDTH       default prescaler counter width
//   DEF_DEBOUNCE_CYCLES default number of stable cycles to accept a button level
//   cnt_width()         width of a counter that must hold 0..cycles-1
package spin_step_pkg;

  typedef enum logic [1:0] {
    PAUSED  = 2'd0,
    RUNNING = 2'd1,
    STEP    = 2'd2
  } spin_state_t;

  localparam int DEF_DIV_SHIFT_MIN   = 8;
  localparam int DEF_DIV_WIDTH       = 15;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  // A one-cycle debounce window still needs a 1-bit counter so the
  // comparison against (cycles-1) stays well formed.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: conditions one raw asynchronous push button.
//
// A 2-flop synchroniser feeds a stability counter; the debounced level only
// follows the synchronised input after it has differed for DEBOUNCE_CYCLES
// consecutive cycles. A one-cycle press pulse marks each debounced rising edge.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous reset, active low
//   btn    in   raw button input, active high
//   press  out  one-cycle pulse on the debounced 0->1 transition
module btn_debounce
  import spin_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_q;
  logic [CW-1:0] stable_cnt;
  logic          level_q;
  logic          level_prev;

  // The counter measures how long the synchronised input has disagreed with
  // the accepted level; any agreement restarts the measurement, so a bounce
  // shorter than the window never reaches the flip point.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta  <= 1'b0;
      sync_q     <= 1'b0;
      stable_cnt <= '0;
      level_q    <= 1'b0;
      level_prev <= 1'b0;
    end else begin
      sync_meta  <= btn;
      sync_q     <= sync_meta;
      level_prev <= level_q;
      if (sync_q == level_q) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        level_q    <= ~level_q;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

  assign press = level_q & ~level_prev;

endmodule

// File: rtl/spin_step_ctrl.sv
// spin_step_ctrl: upstream stage of the segment spinner. Converts raw pins
// into a one-cycle advance strobe plus a direction bit for the rotating
// shift register.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous reset, active low
//   run_btn     in   raw run/pause button (active high)
//   step_btn    in   raw single-step button (active high)
//   dir_sw      in   raw direction switch (0 = left, 1 = right)
//   speed[2:0]  in   prescaler select, quasi-static, used unsynchronised
//   step        out  one-cycle advance strobe
//   step_dir    out  direction qualifying step
//   running     out  high while in RUNNING
//   step_count  out  (SPIN_STEP_COUNT_EN only) wrapping count of strobes
//
// Build option: define SPIN_STEP_COUNT_EN to add the step_count output.
module spin_step_ctrl
  import spin_step_pkg::*;
#(
  parameter int DIV_SHIFT_MIN   = DEF_DIV_SHIFT_MIN,
  parameter int DIV_WIDTH       = DEF_DIV_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_btn,
  input  logic       step_btn,
  input  logic       dir_sw,
  input  logic [2:0] speed,
  output logic       step,
  output logic       step_dir,
  output logic       running
`ifdef SPIN_STEP_COUNT_EN
  ,
  output logic [7:0] step_count
`endif
);

  logic                 run_press;
  logic                 step_press;
  logic                 dir_meta;
  logic                 dir_sync;
  logic [2:0]           speed_q;
  logic [DIV_WIDTH-1:0] presc;
  logic [DIV_WIDTH-1:0] tc;
  logic                 tick;
  logic                 presc_clear;
  logic                 step_load;
  spin_state_t          state;
  spin_state_t          next_state;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_db (
    .clk  (clk),
    .reset(reset),
    .btn  (run_btn),
    .press(run_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk  (clk),
    .reset(reset),
    .btn  (step_btn),
    .press(step_press)
  );

  // The direction switch only qualifies strobes, so it needs no debounce,
  // just a clean synchronous copy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_meta <= 1'b0;
      dir_sync <= 1'b0;
    end else begin
      dir_meta <= dir_sw;
      dir_sync <= dir_meta;
    end
  end

  // Terminal count is 2^(DIV_SHIFT_MIN+speed)-1, i.e. a mask of ones below
  // the selected bit position.
  always_comb begin
    tc = '0;
    for (int i = 0; i < DIV_WIDTH; i++) begin
      tc[i] = (i < DIV_SHIFT_MIN + int'(speed));
    end
  end

  assign tick = (state == RUNNING) && (presc == tc);

  // Next-state decision; a run press always wins over a step press, and
  // anything arriving while in STEP is simply not looked at.
  always_comb begin
    next_state = state;
    case (state)
      PAUSED: begin
        if (run_press) begin
          next_state = RUNNING;
        end else if (step_press) begin
          next_state = STEP;
        end
      end
      RUNNING: begin
        if (run_press) begin
          next_state = PAUSED;
        end
      end
      STEP:    next_state = PAUSED;
      default: next_state = PAUSED;
    endcase
  end

  // A tick still produces its strobe even if the same cycle pauses the FSM.
  assign step_load   = tick || ((state == PAUSED) && (next_state == STEP));
  assign presc_clear = (state != RUNNING) || (next_state != RUNNING) || (speed != speed_q);

  // State, prescaler and all outputs are registered together so every
  // output changes on the same edge as the state that implies it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= PAUSED;
      presc    <= '0;
      speed_q  <= 3'd0;
      step     <= 1'b0;
      step_dir <= 1'b0;
      running  <= 1'b0;
    end else begin
      state   <= next_state;
      speed_q <= speed;
      running <= (next_state == RUNNING);
      step    <= step_load;
      if (step_load) begin
        step_dir <= dir_sync;
      end
      if (presc_clear || (presc == tc)) begin
        presc <= '0;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

`ifdef SPIN_STEP_COUNT_EN
  // Free-running 8-bit tally of strobes, wrapping naturally at 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_count <= 8'd0;
    end else if (step) begin
      step_count <= step_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spin_step_ctrl.sv
// tb_spin_step_ctrl: self-checking bench for spin_step_ctrl built with
// DIV_SHIFT_MIN=2 and DEBOUNCE_CYCLES=3. A cycle-level reference model of the
// controller's rules runs in lockstep; a table of hand-derived vectors and a
// few hand sequences add independent expectations on top of it.
module tb_spin_step_ctrl;

  localparam int SHIFT     = 2;
  localparam int DEB       = 3;
  localparam int WID       = 15;
  localparam int HIST_MASK = (1 << DEB) - 1;
  localparam int NV        = 11;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       run_btn  = 1'b0;
  logic       step_btn = 1'b0;
  logic       dir_sw   = 1'b0;
  logic [2:0] speed    = 3'd0;
  logic       step;
  logic       step_dir;
  logic       running;
`ifdef SPIN_STEP_COUNT_EN
  logic [7:0] step_count;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int pulse_cnt   = 0;
  int rise_cnt    = 0;
  bit prev_running = 1'b0;

  // reference model state
  int m_run_raw, m_stp_raw, m_dir_raw;
  int m_run_hist, m_stp_hist;
  bit m_run_lvl, m_run_prev, m_stp_lvl, m_stp_prev;
  int m_mode;
  int m_phase;
  int m_speed_prev;
  int m_count;
  bit m_step, m_dir, m_running;

  typedef struct {
    bit run;
    bit stp;
    bit dir;
    int spd;
    int hold;
    int exp_pulses;
    int exp_running;
    int exp_dir;
  } vec_t;

  vec_t tbl[NV];

  spin_step_ctrl #(
    .DIV_SHIFT_MIN  (SHIFT),
    .DIV_WIDTH      (WID),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run_btn   (run_btn),
    .step_btn  (step_btn),
    .dir_sw    (dir_sw),
    .speed     (speed),
    .step      (step),
    .step_dir  (step_dir),
    .running   (running)
`ifdef SPIN_STEP_COUNT_EN
    ,
    .step_count(step_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    m_run_raw = 0; m_stp_raw = 0; m_dir_raw = 0;
    m_run_hist = 0; m_stp_hist = 0;
    m_run_lvl = 0; m_run_prev = 0; m_stp_lvl = 0; m_stp_prev = 0;
    m_mode = 0; m_phase = 0; m_speed_prev = 0; m_count = 0;
    m_step = 0; m_dir = 0; m_running = 0;
  endtask

  // A button level is accepted once the last DEB synchronised samples all
  // disagree with the currently accepted level.
  task automatic modelDebounce(input bit synced, inout int hist, inout bit lvl, inout bit prev);
    prev = lvl;
    hist = ((hist << 1) | int'(synced)) & HIST_MASK;
    if (hist == (lvl ? 0 : HIST_MASK)) lvl = ~lvl;
  endtask

  // One clock edge of the controller. Modes: 0 paused, 1 running, 2 single step.
  task automatic modelStep(input bit rin, input bit sin, input bit din, input int spd);
    bit run_sync, stp_sync, dir_sync, run_press, stp_press, tick, load;
    int period, nmode;
    run_sync  = m_run_raw[1];
    stp_sync  = m_stp_raw[1];
    dir_sync  = m_dir_raw[1];
    run_press = m_run_lvl && !m_run_prev;
    stp_press = m_stp_lvl && !m_stp_prev;
    period    = 1 << (SHIFT + spd);
    tick      = (m_mode == 1) && (m_phase == period - 1);
    if (m_mode == 0)      nmode = run_press ? 1 : (stp_press ? 2 : 0);
    else if (m_mode == 1) nmode = run_press ? 0 : 1;
    else                  nmode = 0;
    load = tick || (m_mode == 0 && nmode == 2);
    m_count = (m_count + int'(m_step)) % 256;
    if (load) m_dir = dir_sync;
    m_step    = load;
    m_running = (nmode == 1);
    if (m_mode == 1 && nmode == 1 && spd == m_speed_prev)
      m_phase = (m_phase == period - 1) ? 0 : m_phase + 1;
    else
      m_phase = 0;
    m_speed_prev = spd;
    m_mode = nmode;
    modelDebounce(run_sync, m_run_hist, m_run_lvl, m_run_prev);
    modelDebounce(stp_sync, m_stp_hist, m_stp_lvl, m_stp_prev);
    m_run_raw = ((m_run_raw << 1) | int'(rin)) & 3;
    m_stp_raw = ((m_stp_raw << 1) | int'(sin)) & 3;
    m_dir_raw = ((m_dir_raw << 1) | int'(din)) & 3;
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit d, input logic [2:0] spd);
    run_btn  = r;
    step_btn = s;
    dir_sw   = d;
    speed    = spd;
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic checkOutput(input string name);
    vectors++;
    if ({step, step_dir, running} !== {m_step, m_dir, m_running}) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: step/dir/running got %b%b%b, expected %b%b%b",
               name, $time, step, step_dir, running, m_step, m_dir, m_running);
    end
`ifdef SPIN_STEP_COUNT_EN
    checkValue({name, "_count"}, int'(step_count), m_count);
`endif
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelStep(run_btn, step_btn, dir_sw, int'(speed));
      @(negedge clk);
      checkOutput("model");
      if (step) pulse_cnt++;
      if (running && !prev_running) rise_cnt++;
      prev_running = running;
    end
  endtask

  task automatic doReset(input int cycles);
    reset = 1'b0;
    modelReset();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    prev_running = 1'b0;
  endtask

  initial begin
    bit found;

    //            run stp dir spd hold pulses running dir
    tbl[0]  = '{0, 0, 0, 0, 20,  0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0,  6,  0, 1, 0};
    tbl[2]  = '{1, 0, 0, 0, 40, 10, 1, 0};
    tbl[3]  = '{0, 0, 1, 0, 20,  5, 1, 1};
    tbl[4]  = '{1, 0, 1, 0,  6,  1, 0, 1};
    tbl[5]  = '{0, 0, 1, 0, 20,  0, 0, 1};
    tbl[6]  = '{0, 1, 0, 0, 10,  1, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 10,  0, 0, 0};
    tbl[8]  = '{1, 0, 0, 0,  6,  0, 1, 0};
    tbl[9]  = '{0, 0, 0, 2, 40,  2, 1, 0};
    tbl[10] = '{1, 0, 0, 2,  6,  0, 0, 0};

    doReset(3);
    checkValue("reset_state", int'({step, step_dir, running}), 0);
    checkOutput("reset_model");

    // table-driven vectors
    for (int v = 0; v < NV; v++) begin
      applyStimulus(tbl[v].run, tbl[v].stp, tbl[v].dir, 3'(tbl[v].spd));
      pulse_cnt = 0;
      runCycles(tbl[v].hold);
      checkValue($sformatf("vec%0d_pulses", v), pulse_cnt, tbl[v].exp_pulses);
      checkValue($sformatf("vec%0d_running", v), int'(running), tbl[v].exp_running);
      checkValue($sformatf("vec%0d_dir", v), int'(step_dir), tbl[v].exp_dir);
    end

    // bouncing run button: exactly one press, then a clean press pauses
    applyStimulus(0, 0, 0, 3'd0);
    runCycles(10);
    rise_cnt = 0;
    applyStimulus(1, 0, 0, 3'd0);
    runCycles(1);
    applyStimulus(0, 0, 0, 3'd0);
    runCycles(1);
    applyStimulus(1, 0, 0, 3'd0);
    runCycles(30);
    checkValue("bounce_single_press", rise_cnt, 1);
    checkValue("bounce_running", int'(running), 1);
    applyStimulus(0, 0, 0, 3'd0);
    runCycles(10);
    applyStimulus(1, 0, 0, 3'd0);
    runCycles(8);
    checkValue("clean_pause", int'(running), 0);
    applyStimulus(0, 0, 0, 3'd0);
    pulse_cnt = 0;
    runCycles(20);
    checkValue("paused_no_steps", pulse_cnt, 0);

    // simultaneous run and step press: run wins, step presses ignored
    pulse_cnt = 0;
    applyStimulus(1, 1, 0, 3'd0);
    runCycles(8);
    checkValue("simul_no_single_step", pulse_cnt, 0);
    checkValue("simul_running", int'(running), 1);
    pulse_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 0, 3'd0);
      runCycles(6);
      applyStimulus(0, 0, 0, 3'd0);
      runCycles(6);
    end
    runCycles(4);
    checkValue("run_ignores_step", pulse_cnt, 10);

    // asynchronous reset while a strobe is high
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      runCycles(1);
      if (step) found = 1'b1;
    end
    checkValue("wait_step_seen", int'(found), 1);
    reset = 1'b0;
    #1;
    checkValue("async_reset_drop", int'({step, running}), 0);
`ifdef SPIN_STEP_COUNT_EN
    checkValue("async_reset_count", int'(step_count), 0);
`endif
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    prev_running = 1'b0;
    checkOutput("after_reset");

`ifdef SPIN_STEP_COUNT_EN
    // step_count wraps 255 -> 0 on the 256th strobe
    applyStimulus(1, 0, 0, 3'd0);
    pulse_cnt = 0;
    runCycles(8);
    applyStimulus(0, 0, 0, 3'd0);
    for (int i = 0; i < 1500 && pulse_cnt < 256; i++) runCycles(1);
    checkValue("count_256_pulses", pulse_cnt, 256);
    checkValue("count_at_255", int'(step_count), 255);
    runCycles(1);
    checkValue("count_wrapped", int'(step_count), 0);
    doReset(2);
    checkValue("count_reset", int'(step_count), 0);
`endif

    // randomized stimulus against the reference model
    doReset(2);
    applyStimulus(0, 0, 0, 3'd0);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39, 0) == 0) run_btn  = ~run_btn;
      if ($urandom_range(29, 0) == 0) step_btn = ~step_btn;
      if ($urandom_range(49, 0) == 0) dir_sw   = ~dir_sw;
      if ($urandom_range(499, 0) == 0) speed   = 3'($urandom_range(1, 0));
      runCycles(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spin_step_ctrl.md
Name: spin_step_ctrl

Overview:
- Upstream stage of the tiny-tapeout segment spinner.
- Turns raw pin inputs (run button, step button, direction switch, 3-bit speed select) into a one-cycle `step` strobe plus a direction bit.
- The downstream rotating shift register advances once per strobe.
- Provides synchronisation, debouncing, a speed-programmable prescaler, and a run/pause/single-step state machine.

Parameters:
- DIV_SHIFT_MIN, 8, log2 of the prescaler period at speed=0.
- DIV_WIDTH, 15, prescaler counter width; must be >= DIV_SHIFT_MIN+7.
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles required to accept a new button level (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- run_btn  input  1  raw asynchronous run/pause button, active-high
- step_btn  input  1  raw asynchronous single-step button, active-high
- dir_sw  input  1  raw direction switch (0 = left, 1 = right)
- speed  input  3  prescaler select, sampled directly (quasi-static)
- step  output  1  one-cycle advance strobe to the spinner
- step_dir  output  1  direction qualifying `step`
- running  output  1  high while in RUNNING state

Behaviour:
- Reset values: all flops 0; step=0, step_dir=0, running=0; FSM=PAUSED; prescaler=0; debounced levels=0.
- Synchronisers:
  - run_btn, step_btn and dir_sw each pass through a 2-flop synchroniser.
  - speed is not synchronised.
- Debounce (per button):
  - A counter increments while the synced value differs from the debounced level, and clears when they match.
  - When the count reaches DEBOUNCE_CYCLES-1 and the values still differ, the debounced level flips on the next edge and the counter clears.
- Press:
  - A press is the cycle where the debounced level is 1 and its previous-cycle copy is 0 (rising edge only).
  - Latency from a clean input edge to the press cycle is 2+DEBOUNCE_CYCLES clocks.
- Prescaler:
  - TC = 2^(DIV_SHIFT_MIN+speed) - 1.
  - Counts only in RUNNING and wraps to 0 at TC.
  - tick = (count == TC) in RUNNING.
  - Cleared to 0 on leaving RUNNING and whenever speed differs from its registered previous value.
- FSM:
  - PAUSED: run press -> RUNNING; else step press -> STEP.
  - RUNNING: run press -> PAUSED; step presses are ignored.
  - STEP: unconditionally -> PAUSED after one cycle; presses during STEP are dropped.
  - Simultaneous run and step press in PAUSED: run wins, go to RUNNING.
- Outputs (all registered):
  - step = 1 on the cycle after a tick, and for the one cycle after entering STEP.
  - step_dir is loaded from synced dir_sw only in the same cycle step is loaded high; otherwise it holds.
  - running = (next state == RUNNING), registered.
- Run press coinciding with tick: the tick's strobe is still emitted; the FSM goes to PAUSED.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); step deasserts without completing.

Optional Feature:
- SPIN_STEP_COUNT_EN defined:
  - Adds output step_count[7:0].
  - Increments on every cycle step=1 and wraps 255 -> 0.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package spin_step_pkg:
  - FSM state enum: PAUSED=2'd0, RUNNING=2'd1, STEP=2'd2.
  - Default parameter constants.
- Sub-module btn_debounce:
  - Synchroniser, debounce counter and rising-edge pulse.
  - Instantiated twice for run_btn and step_btn; dir_sw uses the synchroniser only.

Test Plan (DIV_SHIFT_MIN=2, DEBOUNCE_CYCLES=3):
1. Reset low 3 cycles then high, no buttons -> step=0, running=0, step_dir=0 for 100 cycles.
2. run_btn high at cycle 10 and held -> running=1 at cycle 16, then step pulses every 4 cycles at speed=0, and every 16 cycles after speed set to 2 (first pulse 16 cycles after the change).
3. run_btn bouncing 1-0-1 with 1-cycle widths, then stable 1 -> exactly one press; a second clean press returns to PAUSED with no further step.
4. In PAUSED with dir_sw=1, press step_btn -> exactly one step pulse with step_dir=1, 6 cycles after the input edge; then FSM is in PAUSED.
5. run_btn and step_btn rise in the same cycle while PAUSED -> RUNNING and no single-step pulse. Step presses while RUNNING -> no extra pulses.
6. Reset asserted mid-run with step=1 -> step and running drop at once; with SPIN_STEP_COUNT_EN, step_count increments 255 -> 0 on the 256th pulse and clears on reset.
